// File: rtl/stopwatch_bcd_display_pkg.sv
// Purpose: shared types and constants for the mm:ss stopwatch and its 7-segment scan.
// Latency: none (types, constants and a pure function only).
// Backpressure: none; nothing here holds state.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } sw_state_t;

    // Active-low {dp,g,f,e,d,c,b,a}, dp off.
    localparam logic [7:0] SEG_LUT [0:9] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
        8'h92, 8'h82, 8'hF8, 8'h80, 8'h90
    };
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // Scan order, right to left across the display.
    localparam logic [1:0] DIGIT_SS_ONES = 2'd0;
    localparam logic [1:0] DIGIT_SS_TENS = 2'd1;
    localparam logic [1:0] DIGIT_MM_ONES = 2'd2;
    localparam logic [1:0] DIGIT_MM_TENS = 2'd3;

    // Pattern for one BCD digit; dp_on pulls the (active-low) dp bit low.
    function automatic logic [7:0] seg_encode(input logic [3:0] digit, input logic dp_on);
        logic [7:0] pat;
        if (digit <= 4'd9) pat = SEG_LUT[digit];
        else               pat = SEG_BLANK;
        if (dp_on) pat[7] = 1'b0;
        return pat;
    endfunction

endpackage

// File: rtl/stopwatch_bcd_display_if.sv
// Purpose: control inputs and display/count outputs of the stopwatch bundled as one port.
// Latency: none (wires only).
// Backpressure: none; all signals are pulses or levels with no handshake.
// master: drives tick/start_stop/clr, observes AN/SEG/mm/ss/running/wrap.
// slave : the stopwatch itself.
interface stopwatch_bcd_display_if;
    logic       tick;
    logic       start_stop;
    logic       clr;
    logic [3:0] AN;
    logic [7:0] SEG;
    logic [7:0] mm;
    logic [7:0] ss;
    logic       running;
    logic       wrap;

    modport master (
        output tick, start_stop, clr,
        input  AN, SEG, mm, ss, running, wrap
    );

    modport slave (
        input  tick, start_stop, clr,
        output AN, SEG, mm, ss, running, wrap
    );
endinterface

// File: rtl/stopwatch_bcd_display_bcd_mod60.sv
// Purpose: two-digit BCD counter 00..59 with increment, synchronous clear and carry-out.
// Latency: val updates one CP after inc/clr; carry is combinational from inc and val.
// Backpressure: none; every inc is accepted.
// Ports: CP clock, CR async active-low reset, inc count enable, clr sync clear,
//        val {tens,ones} BCD, carry = inc while val is 59.
module bcd_mod60 (
    input  logic       CP,
    input  logic       CR,
    input  logic       inc,
    input  logic       clr,
    output logic [7:0] val,
    output logic       carry
);

    logic [7:0] val_q;
    logic [7:0] val_d;

    always_comb begin
        val_d = val_q;
        if (clr) begin
            val_d = 8'h00;
        end else if (inc) begin
            if (val_q[3:0] == 4'd9) begin
                val_d[3:0] = 4'd0;
                if (val_q[7:4] == 4'd5) val_d[7:4] = 4'd0;
                else                    val_d[7:4] = val_q[7:4] + 4'd1;
            end else begin
                val_d[3:0] = val_q[3:0] + 4'd1;
            end
        end
    end

    always_ff @(posedge CP or negedge CR) begin
        if (!CR) val_q <= 8'h00;
        else     val_q <= val_d;
    end

    assign val   = val_q;
    assign carry = inc && (val_q == 8'h59);

endmodule

// File: rtl/stopwatch_bcd_display.sv
// Purpose: mm:ss BCD stopwatch with start/stop/clear, scanned onto a common-anode 4-digit display.
// Latency: counts, flags and display outputs are registered, visible one CP after the qualifying edge.
// Backpressure: none; tick/start_stop/clr are one-cycle pulses sampled every CP.
// Ports: CP clock, CR async active-low reset, bus (slave modport) carrying tick/start_stop/clr in
//        and AN/SEG/mm/ss/running/wrap out.
module stopwatch_bcd_display
    import stopwatch_pkg::*;
#(
    parameter int SCAN_DIV = 50000
) (
    input  logic                      CP,
    input  logic                      CR,
    stopwatch_bcd_display_if.slave    bus
);

    localparam int                SCAN_W    = $clog2(SCAN_DIV);
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);

    // ---------------- run/pause FSM ----------------
    sw_state_t state_q;
    logic      running_q;

    always_ff @(posedge CP or negedge CR) begin
        if (!CR) begin
            state_q   <= IDLE;
            running_q <= 1'b0;
        end else if (bus.clr) begin
            state_q   <= IDLE;
            running_q <= 1'b0;
        end else if (bus.start_stop) begin
            case (state_q)
                IDLE:    begin state_q <= RUN;   running_q <= 1'b1; end
                RUN:     begin state_q <= PAUSE; running_q <= 1'b0; end
                PAUSE:   begin state_q <= RUN;   running_q <= 1'b1; end
                default: begin state_q <= IDLE;  running_q <= 1'b0; end
            endcase
        end
    end

    // ---------------- counters ----------------
    // Gated on the current state, so a tick coinciding with the pulse that leaves
    // RUN still counts while one coinciding with the pulse that enters RUN does not.
    logic       count_en;
    logic [7:0] ss_val;
    logic [7:0] mm_val;
    logic       sec_carry;
    logic       min_carry;

    assign count_en = (state_q == RUN) && bus.tick && !bus.clr;

    bcd_mod60 u_sec (
        .CP    (CP),
        .CR    (CR),
        .inc   (count_en),
        .clr   (bus.clr),
        .val   (ss_val),
        .carry (sec_carry)
    );

    bcd_mod60 u_min (
        .CP    (CP),
        .CR    (CR),
        .inc   (sec_carry),
        .clr   (bus.clr),
        .val   (mm_val),
        .carry (min_carry)
    );

    logic wrap_q;
    logic wrap_d;

    // Minutes carry only fires on the 59:59 -> 00:00 step.
    assign wrap_d = min_carry;

    // ---------------- display scan ----------------
    logic [SCAN_W-1:0] scan_cnt_q, scan_cnt_d;
    logic [1:0]        digit_idx_q, digit_idx_d;
    logic [3:0]        an_q, an_d;
    logic [7:0]        seg_q, seg_d;
    logic [3:0]        digit_sel;

    always_comb begin
        scan_cnt_d  = scan_cnt_q + SCAN_W'(1);
        digit_idx_d = digit_idx_q;
        if (scan_cnt_q == SCAN_LAST) begin
            scan_cnt_d  = '0;
            digit_idx_d = digit_idx_q + 2'd1;
        end
    end

    // AN and SEG are both derived from the next index so they switch on the same edge.
    always_comb begin
        digit_sel = 4'd0;
        case (digit_idx_d)
            DIGIT_SS_ONES: digit_sel = ss_val[3:0];
            DIGIT_SS_TENS: digit_sel = ss_val[7:4];
            DIGIT_MM_ONES: digit_sel = mm_val[3:0];
            DIGIT_MM_TENS: digit_sel = mm_val[7:4];
            default:       digit_sel = 4'd0;
        endcase
        an_d  = ~(4'b0001 << digit_idx_d);
        seg_d = seg_encode(digit_sel, digit_idx_d == DIGIT_MM_ONES);
    end

    always_ff @(posedge CP or negedge CR) begin
        if (!CR) begin
            scan_cnt_q  <= '0;
            digit_idx_q <= 2'd0;
            an_q        <= 4'b1110;
            seg_q       <= 8'hC0;
            wrap_q      <= 1'b0;
        end else begin
            scan_cnt_q  <= scan_cnt_d;
            digit_idx_q <= digit_idx_d;
            an_q        <= an_d;
            seg_q       <= seg_d;
            wrap_q      <= wrap_d;
        end
    end

    assign bus.AN      = an_q;
    assign bus.SEG     = seg_q;
    assign bus.mm      = mm_val;
    assign bus.ss      = ss_val;
    assign bus.running = running_q;
    assign bus.wrap    = wrap_q;

endmodule

// File: doc/stopwatch_bcd_display.md
Name: stopwatch_bcd_display

Overview:
- Downstream consumer of the 4-bit synchronous prescaler counter chain.
- Takes the chain's carry-out as a once-per-second tick enable and keeps an mm:ss stopwatch in BCD.
- The stopwatch has start/stop/clear control.
- Time-multiplexes the four BCD digits onto a common-anode 4-digit 7-segment display.

Parameters:
- SCAN_DIV, 50000: CP cycles each digit stays lit. Legal range ≥2. Scan counter width is $clog2(SCAN_DIV).

Ports:
- CP  in  1  system clock, rising-edge active.
- CR  in  1  asynchronous active-low reset. Clears all state immediately on assertion, independent of CP.
- tick  in  1  one-CP-cycle active-high count enable from the upstream counter carry-out.
- start_stop  in  1  one-cycle pulse from an upstream debounce/one-shot; toggles run/pause.
- clr  in  1  one-cycle synchronous clear pulse.
- AN  out  4  digit enables, active-low, one-hot-zero. Bit 0 is the rightmost digit.
- SEG  out  8  {dp,g,f,e,d,c,b,a}, active-low.
- mm  out  8  minutes as {tens,ones} BCD.
- ss  out  8  seconds as {tens,ones} BCD.
- running  out  1  high while in RUN.
- wrap  out  1  one-cycle pulse on rollover from 59:59 to 00:00.

Behaviour:
- Reset (CR=0) values:
  - state=IDLE, mm=8'h00, ss=8'h00, running=0, wrap=0.
  - Scan counter=0, digit index=0, AN=4'b1110, SEG=8'hC0 (digit '0', dp off).
- All non-reset updates happen on rising CP. Inputs are sampled synchronously. Counts and flags are registered and visible one cycle after the qualifying edge.
- FSM states IDLE, RUN, PAUSE:
  - IDLE: start_stop -> RUN.
  - RUN: start_stop -> PAUSE.
  - PAUSE: start_stop -> RUN.
  - Any state: clr -> IDLE with mm=ss=00. clr has priority over start_stop and tick in the same cycle.
- Counting happens only when state==RUN and tick==1 in the same cycle, with no clr.
  - tick in IDLE or PAUSE is ignored.
  - A tick in the same cycle as a start_stop that leaves RUN is still counted, because the counter is evaluated on the current state.
  - A tick in the same cycle as a start_stop that enters RUN is not counted.
- Count rules:
  - ss ones digit counts 0..9. On 9 it returns to 0 and increments ss tens.
  - ss tens digit counts 0..5. At ss=59 the count goes to ss=00 and mm increments, with the same BCD rule.
  - At mm:ss=59:59, a tick gives 00:00, wrap=1 for exactly one cycle, and state stays RUN.
- Digit values never leave the BCD range. A non-BCD value is unreachable and needs no handling.
- running = (state==RUN), registered.
- Display scan:
  - The scan counter counts 0..SCAN_DIV-1 continuously, independent of the FSM and clr.
  - At terminal count the digit index advances 0->1->2->3->0.
  - Index 0 = ss ones, 1 = ss tens, 2 = mm ones, 3 = mm tens.
  - AN = ~(1<<index). SEG = 7-segment pattern of the selected digit. dp is low (lit) only on index 2, giving "mm.ss".
  - AN and SEG are registered and change on the same edge. There is no ghosting cycle in which a new AN appears with old SEG.
- Segment patterns (active-low, dp off): 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90.
- CR asserted mid-count or mid-scan: all registers return to their reset values asynchronously. The first counting edge needs CR released and start_stop.

Decomposition:
- Shared package stopwatch_pkg:
  - State enum {IDLE, RUN, PAUSE}.
  - SEG_LUT constant array for digits 0..9.
  - SEG_BLANK = 8'hFF.
  - DIGIT_* index constants.
- Sub-module bcd_mod60: one instance for seconds, one for minutes.
  - Ports: CP, CR, inc, clr, val[7:0], carry.
  - carry is combinational: inc && val==8'h59.
  - The minutes instance's inc = seconds carry. wrap is registered from the minutes carry.

Test Plan:
- Reset and display: CR=0 for 3 cycles then 1, SCAN_DIV=4 -> mm=ss=00, running=0, and AN steps 1110->1101->1011->0111 every 4 cycles. SEG is C0, C0, 40 (dp lit), C0 in turn.
- Basic count: start_stop pulse, then 12 tick pulses -> ss=8'h12, mm=8'h00, running=1. Display index 1 shows SEG=F9.
- Pause/priority: in RUN, tick+start_stop in the same cycle -> count +1, state PAUSE. Three further ticks leave ss unchanged. clr+start_stop in the same cycle -> IDLE, 00:00.
- Minute carry: preload by ticking to 00:59, then one tick -> 01:00. Index 2 shows SEG=79 (digit 1 with dp).
- Full wrap: 3599 ticks give 59:59, then one tick -> 00:00, wrap high exactly one cycle, running stays 1.
- Async reset mid-run: at 12:34, drop CR between CP edges -> outputs hit reset values before the next edge. After release, a tick without start_stop leaves 00:00.
